// File: rtl/div_restoring_if.sv
// div_restoring_if: operand/result bundle for the restoring divider.
// The master side issues start/operands; the slave side returns the quotient,
// remainder, done flag and error flag.
interface div_restoring_if;
    logic       start;
    logic [7:0] initD;
    logic [3:0] initM;
    logic [3:0] cociente;
    logic [3:0] resto;
    logic       fin;
    logic       err;

    modport master (
        output start,
        output initD,
        output initM,
        input  cociente,
        input  resto,
        input  fin,
        input  err
    );

    modport slave (
        input  start,
        input  initD,
        input  initM,
        output cociente,
        output resto,
        output fin,
        output err
    );
endinterface

// File: rtl/div_restoring.sv
// div_restoring: 8-bit by 4-bit unsigned restoring divider.
// One SHIFT/SUB pair per quotient bit, four iterations, result held in DONE
// until start drops.
// Optional macro DIV_ERR_EN: flags divide-by-zero and quotient overflow at the
// start edge and jumps straight to DONE with err=1, quotient 4'hF, remainder 0.
// Without it err is constant 0 and out-of-range operands give raw results.
module div_restoring (
    input  logic           clk,
    input  logic           reset_n,
    div_restoring_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StSub   = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e     r_state;
    logic [4:0] r_a;    // partial remainder, bit 4 is the carry/sign position
    logic [3:0] r_q;
    logic [3:0] r_m;
    logic [2:0] r_cnt;
    logic       r_fin;
    logic       r_err;

    logic [4:0] w_diff;
    logic       w_chk_err;

    assign w_diff = r_a - {1'b0, r_m};

`ifdef DIV_ERR_EN
    // Divisor zero, or upper dividend nibble already >= divisor (quotient > 15).
    assign w_chk_err = (bus.initM == 4'd0) || (bus.initD[7:4] >= bus.initM);
`else
    assign w_chk_err = 1'b0;
`endif

    assign bus.cociente = r_q;
    assign bus.resto    = r_a[3:0];
    assign bus.fin      = r_fin;
    assign bus.err      = r_err;

    // Control FSM and datapath registers, outputs registered alongside state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_a     <= 5'd0;
            r_q     <= 4'd0;
            r_m     <= 4'd0;
            r_cnt   <= 3'd0;
            r_fin   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_m   <= bus.initM;
                        r_cnt <= 3'd4;
                        if (w_chk_err) begin
                            r_a     <= 5'd0;
                            r_q     <= 4'hF;
                            r_err   <= 1'b1;
                            r_fin   <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_a     <= {1'b0, bus.initD[7:4]};
                            r_q     <= bus.initD[3:0];
                            r_err   <= 1'b0;
                            r_state <= StShift;
                        end
                    end
                end
                StShift: begin
                    // Q[0] is don't-care here; SUB writes the real quotient bit.
                    r_a     <= {r_a[3:0], r_q[3]};
                    r_q     <= {r_q[2:0], 1'b0};
                    r_state <= StSub;
                end
                StSub: begin
                    if (!w_diff[4]) begin
                        r_a    <= w_diff;
                        r_q[0] <= 1'b1;
                    end else begin
                        r_q[0] <= 1'b0;
                    end
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_fin   <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_state <= StShift;
                    end
                end
                StDone: begin
                    if (!bus.start) begin
                        r_fin   <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_restoring.sv
// tb_div_restoring: directed-vector bench for div_restoring.
// Expectations track the DIV_ERR_EN setting of the build.
module tb_div_restoring;

`ifdef DIV_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_bad;

    div_restoring_if bus_if ();

    div_restoring dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and start, return 1 time unit after the start edge.
    task automatic launch(input logic [7:0] d, input logic [3:0] m, input bit keep);
        bus_if.initD = d;
        bus_if.initM = m;
        bus_if.start = 1'b1;
        tick();
        if (!keep) bus_if.start = 1'b0;
    endtask

    // Edge number (start edge = 1) after which fin was first seen, -1 on timeout.
    task automatic wait_fin(output int edges);
        edges = 1;
        while (!bus_if.fin && edges < 20) begin
            tick();
            edges++;
        end
        if (!bus_if.fin) edges = -1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus_if.start = 1'b0;
        bus_if.initD = 8'd0;
        bus_if.initM = 4'd0;
        #2;
        n_vec++;
        if ({bus_if.fin, bus_if.err, bus_if.cociente, bus_if.resto} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0",
                     {bus_if.fin, bus_if.err, bus_if.cociente, bus_if.resto});
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus_if.initD = 8'd100;
        bus_if.initM = 4'd7;
        for (int i = 0; i < 3; i++) tick();
        n_vec++;
        if ({bus_if.fin, bus_if.cociente, bus_if.resto} !== 9'd0) begin
            n_bad++;
            $display("FAIL idle_hold: got %b want 0",
                     {bus_if.fin, bus_if.cociente, bus_if.resto});
        end
    endtask

    task automatic test_basic();
        int e;
        launch(8'd100, 4'd7, 1'b0);
        wait_fin(e);
        n_vec++;
        if (e !== 9) begin n_bad++; $display("FAIL basic_latency: got %0d want 9", e); end
        n_vec++;
        if (bus_if.cociente !== 4'd14) begin
            n_bad++; $display("FAIL basic_quot: got %0d want 14", bus_if.cociente);
        end
        n_vec++;
        if (bus_if.resto !== 4'd2) begin
            n_bad++; $display("FAIL basic_rem: got %0d want 2", bus_if.resto);
        end
        n_vec++;
        if (bus_if.err !== 1'b0) begin
            n_bad++; $display("FAIL basic_err: got %b want 0", bus_if.err);
        end
        tick();
        n_vec++;
        if ({bus_if.fin, bus_if.cociente, bus_if.resto} !== {1'b0, 4'd14, 4'd2}) begin
            n_bad++;
            $display("FAIL idle_retain: got fin=%b q=%0d r=%0d want fin=0 q=14 r=2",
                     bus_if.fin, bus_if.cociente, bus_if.resto);
        end
    endtask

    task automatic test_max();
        int e;
        launch(8'd239, 4'd15, 1'b0);
        wait_fin(e);
        n_vec++;
        if (e !== 9) begin n_bad++; $display("FAIL max_latency: got %0d want 9", e); end
        n_vec++;
        if ({bus_if.cociente, bus_if.resto, bus_if.err} !== {4'd15, 4'd14, 1'b0}) begin
            n_bad++;
            $display("FAIL max_result: got q=%0d r=%0d err=%b want q=15 r=14 err=0",
                     bus_if.cociente, bus_if.resto, bus_if.err);
        end
        tick();
    endtask

    task automatic test_div_zero();
        int e;
        int exp_e;
        logic exp_err;
        exp_e   = ErrEn ? 1 : 9;
        exp_err = ErrEn;
        launch(8'h12, 4'd0, 1'b0);
        wait_fin(e);
        n_vec++;
        if (e !== exp_e) begin
            n_bad++; $display("FAIL dz_latency: got %0d want %0d", e, exp_e);
        end
        n_vec++;
        if (bus_if.err !== exp_err) begin
            n_bad++; $display("FAIL dz_err: got %b want %b", bus_if.err, exp_err);
        end
        tick();
    endtask

    task automatic test_overflow();
        int e;
        int exp_e;
        logic exp_err;
        exp_e   = ErrEn ? 1 : 9;
        exp_err = ErrEn;
        launch(8'd200, 4'd5, 1'b0);
        wait_fin(e);
        n_vec++;
        if (e !== exp_e) begin
            n_bad++; $display("FAIL ovf_latency: got %0d want %0d", e, exp_e);
        end
        n_vec++;
        if (bus_if.err !== exp_err) begin
            n_bad++; $display("FAIL ovf_err: got %b want %b", bus_if.err, exp_err);
        end
`ifdef DIV_ERR_EN
        n_vec++;
        if ({bus_if.cociente, bus_if.resto} !== {4'hF, 4'h0}) begin
            n_bad++;
            $display("FAIL ovf_result: got q=%h r=%h want q=f r=0",
                     bus_if.cociente, bus_if.resto);
        end
`endif
        tick();
        // err must clear on the next start edge
        launch(8'd100, 4'd7, 1'b0);
        n_vec++;
        if ({bus_if.err, bus_if.fin} !== 2'b00) begin
            n_bad++;
            $display("FAIL err_clear: got err=%b fin=%b want 0 0", bus_if.err, bus_if.fin);
        end
        wait_fin(e);
        tick();
    endtask

    task automatic test_hold();
        int e;
        launch(8'd100, 4'd7, 1'b1);
        bus_if.initD = 8'd239;
        bus_if.initM = 4'd3;
        wait_fin(e);
        n_vec++;
        if (e !== 9) begin n_bad++; $display("FAIL hold_latency: got %0d want 9", e); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({bus_if.fin, bus_if.cociente, bus_if.resto} !== {1'b1, 4'd14, 4'd2}) begin
                n_bad++;
                $display("FAIL hold_stable[%0d]: got fin=%b q=%0d r=%0d want fin=1 q=14 r=2",
                         i, bus_if.fin, bus_if.cociente, bus_if.resto);
            end
        end
        bus_if.start = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({bus_if.fin, bus_if.cociente, bus_if.resto} !== {1'b0, 4'd14, 4'd2}) begin
            n_bad++;
            $display("FAIL hold_release: got fin=%b q=%0d r=%0d want fin=0 q=14 r=2",
                     bus_if.fin, bus_if.cociente, bus_if.resto);
        end
        launch(8'd239, 4'd15, 1'b0);
        wait_fin(e);
        n_vec++;
        if ({bus_if.cociente, bus_if.resto} !== {4'd15, 4'd14}) begin
            n_bad++;
            $display("FAIL hold_restart: got q=%0d r=%0d want q=15 r=14",
                     bus_if.cociente, bus_if.resto);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int e;
        launch(8'd100, 4'd7, 1'b0);
        for (int i = 0; i < 3; i++) tick();  // edge 4: now in SUB of iteration 2
        #3;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({bus_if.fin, bus_if.err, bus_if.cociente, bus_if.resto} !== 10'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %b want 0",
                     {bus_if.fin, bus_if.err, bus_if.cociente, bus_if.resto});
        end
        #2;
        reset_n = 1'b1;
        launch(8'd45, 4'd15, 1'b0);
        wait_fin(e);
        n_vec++;
        if (e !== 9) begin n_bad++; $display("FAIL midreset_latency: got %0d want 9", e); end
        n_vec++;
        if ({bus_if.cociente, bus_if.resto} !== {4'd3, 4'd0}) begin
            n_bad++;
            $display("FAIL midreset_result: got q=%0d r=%0d want q=3 r=0",
                     bus_if.cociente, bus_if.resto);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int e;
        launch(8'd45, 4'd15, 1'b0);
        wait_fin(e);
        tick();
        launch(8'd100, 4'd7, 1'b0);
        wait_fin(e);
        n_vec++;
        if (e !== 9) begin n_bad++; $display("FAIL b2b_latency: got %0d want 9", e); end
        n_vec++;
        if ({bus_if.cociente, bus_if.resto} !== {4'd14, 4'd2}) begin
            n_bad++;
            $display("FAIL b2b_result: got q=%0d r=%0d want q=14 r=2",
                     bus_if.cociente, bus_if.resto);
        end
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_max();
        test_div_zero();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/div_restoring.md
DIV_RESTORING -- requirements
Module: div_restoring

Interface
- REQ-001: clk  input  1  — single clock; all state updates on the rising edge.
- REQ-002: reset_n  input  1  — asynchronous, active-low reset.
- REQ-003: start  input  1  — operation request, level-sampled in IDLE.
- REQ-004: initD  input  8  — unsigned dividend; sampled on the start edge only.
- REQ-005: initM  input  4  — unsigned divisor; sampled on the start edge only.
- REQ-006: cociente  output  4  — quotient, driven directly from register Q.
- REQ-007: resto  output  4  — remainder, driven from A[3:0].
- REQ-008: fin  output  1  — high while in DONE; results are valid.
- REQ-009: err  output  1  — overflow or divide-by-zero flag; valid while fin=1.

Function
- REQ-010: The block SHALL divide an 8-bit unsigned dividend by a 4-bit divisor using the restoring algorithm.
- REQ-011: The restoring algorithm SHALL use these internal registers:
  - A: 5 bits, partial remainder plus sign/carry bit.
  - Q: 4 bits.
  - M: 4 bits.
  - cnt: 3 bits.
- REQ-012: The control FSM SHALL have states IDLE, SHIFT, SUB and DONE, encoded in 2 bits.
- REQ-013: IDLE with start=1 at an edge SHALL load A={1'b0,initD[7:4]}, Q=initD[3:0], M=initM and cnt=4, then go to SHIFT.
- REQ-014: IDLE with start=0 SHALL hold all registers.
- REQ-015: In SHIFT, {A,Q} SHALL shift left one bit (Q[0] undefined until SUB); the next state is SUB.
- REQ-016: In SUB, the block SHALL compute D=A-{1'b0,M} at 5-bit width:
  - D non-negative: A=D and Q[0]=1.
  - Otherwise: A unchanged (restore) and Q[0]=0.
  - cnt SHALL decrement in both cases.
- REQ-017: SUB SHALL go to DONE when cnt decrements to 0; otherwise it SHALL go to SHIFT.
- REQ-018: Latency SHALL be as follows:
  - start sampled at edge 1.
  - Edges 2–9 perform the four SHIFT/SUB pairs.
  - fin=1 after edge 9.
- REQ-019: DONE SHALL hold fin=1, err and the results stable while start=1.
- REQ-020: DONE SHALL return to IDLE at the first edge with start=0.
- REQ-021: A new operation SHALL require start to be low for at least one edge after DONE.
- REQ-022: start SHALL be ignored in SHIFT and SUB.
- REQ-023: Changes on initD and initM outside the start edge SHALL have no effect.
- REQ-024: cociente and resto SHALL retain the last result in IDLE until the next start edge.
- REQ-025: fin SHALL be 0 in IDLE, SHIFT and SUB.
- REQ-026: err SHALL clear on the next start edge.

Reset
- REQ-027: reset_n=0 SHALL immediately force the following, independent of clk:
  - state=IDLE.
  - A=0, Q=0, M=0, cnt=0.
  - fin=0, err=0, cociente=0, resto=0.
- REQ-028: Reset asserted mid-operation (SHIFT, SUB or DONE) SHALL abort the operation with no partial result retained.
- REQ-029: The first start edge after reset_n rises SHALL be honoured normally.

Configuration
- REQ-030: Macro DIV_ERR_EN SHALL enable error detection.
- REQ-031: With DIV_ERR_EN defined, the start edge in IDLE SHALL check initM==0 or initD[7:4]>=initM.
- REQ-032: When that check is true, the block SHALL go directly to DONE with err=1, Q=4'hF and A=0, so fin=1 after edge 1.
- REQ-033: When that check is false, the operation SHALL proceed per REQ-013 with err=0.
- REQ-034: Without DIV_ERR_EN:
  - No check and no early exit.
  - Every operation runs the full 9-edge sequence.
  - err is tied to 0.
  - Results are the raw restoring-algorithm output (deterministic, not meaningful for out-of-range operands).

Verification
- REQ-035: initD=8'd100, initM=4'd7, start pulse -> fin rises after edge 9; cociente=14, resto=2, err=0.
- REQ-036: initD=8'd239, initM=4'd15 -> cociente=15, resto=14, err=0.
- REQ-037: (DIV_ERR_EN) initD=8'd200, initM=4'd5 -> fin after edge 1; err=1, cociente=4'hF, resto=0.
- REQ-038: (DIV_ERR_EN) initM=0, any initD -> fin after edge 1; err=1. Without DIV_ERR_EN: fin after edge 9, err=0.
- REQ-039: reset_n pulsed low during SUB of iteration 2 -> outputs 0 immediately; a following start with 8'd45/4'd15 gives cociente=3, resto=0.
- REQ-040: start held high through DONE, initD changed mid-operation -> fin and results stay stable; no restart until start low then high again.
